// File: rtl/win_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) multiplier sequencer.
package win_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int LANES  = 16;
  localparam int PROD_W = 32;
  localparam int ROW_W  = 128;

  // Multiplier end_signal levels, matching defines.v
  localparam logic Finish   = 1'b1;
  localparam logic UnFinish = 1'b0;

  // WAIT cycles allowed before the multiplier is declared hung
  localparam int WAIT_LIMIT = 4;

  typedef logic signed [PROD_W-1:0] lane_t;

endpackage

// File: rtl/win_acc16.sv
// Sixteen independent 32-bit two's-complement accumulator lanes; flat vector,
// lane 15 in the top bits so the packing mirrors the multiplier rows.
module win_acc16
  import win_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic [LANES*PROD_W-1:0] m_i,
  output logic [LANES*PROD_W-1:0] acc_o
);

  // Modulo-2^32 lane sum; overflow wraps by design
  function automatic lane_t add_wrap(input lane_t a, input lane_t b);
    return a + b;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_t acc_q;
    lane_t prod;

    assign prod = m_i[i*PROD_W +: PROD_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (load_i) begin
        acc_q <= prod;
      end else if (add_i) begin
        acc_q <= add_wrap(acc_q, prod);
      end
    end

    assign acc_o[i*PROD_W +: PROD_W] = acc_q;
  end

endmodule

// File: rtl/win33_mul_ctrl.sv
// Job sequencer around win33_mul: per-channel handshake, multiplier fire,
// per-lane accumulation and hand-off of the 4x4 M tile downstream.
module win33_mul_ctrl
  import win_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   num_ch,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mul_enable,
  input  logic              mul_end,
  input  logic [ROW_W-1:0]  mul_m1,
  input  logic [ROW_W-1:0]  mul_m2,
  input  logic [ROW_W-1:0]  mul_m3,
  input  logic [ROW_W-1:0]  mul_m4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_m1,
  output logic [ROW_W-1:0]  out_m2,
  output logic [ROW_W-1:0]  out_m3,
  output logic [ROW_W-1:0]  out_m4,
  output logic              err
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]   num_ch_q, num_ch_d;
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              acc_load, acc_add;
  logic [LANES*PROD_W-1:0] acc_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_cnt_q    <= '0;
      num_ch_q    <= '0;
      tile_cnt_q  <= '0;
      num_tiles_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      num_ch_q    <= num_ch_d;
      tile_cnt_q  <= tile_cnt_d;
      num_tiles_q <= num_tiles_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    num_ch_d    = num_ch_q;
    tile_cnt_d  = tile_cnt_q;
    num_tiles_d = num_tiles_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    mul_enable  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    acc_load    = 1'b0;
    acc_add     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Zero channels is folded to one so the tile still completes
          num_ch_d    = (num_ch == '0) ? CH_W'(1) : num_ch;
          num_tiles_d = num_tiles;
          ch_cnt_d    = '0;
          tile_cnt_d  = '0;
          err_d       = 1'b0;
          state_d     = (num_tiles == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_enable = in_valid;
        if (in_valid) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mul_end == Finish) begin
          state_d = ST_CAPTURE;
        end else if (wait_cnt_q == 2'(WAIT_LIMIT - 1)) begin
          // Hung multiplier: flag it and flush the channel with junk data
          err_d   = 1'b1;
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_CAPTURE: begin
        in_ready = 1'b1;
        acc_load = (ch_cnt_q == '0);
        acc_add  = (ch_cnt_q != '0);
        if (ch_cnt_q == num_ch_q - CH_W'(1)) begin
          ch_cnt_d = '0;
          state_d  = ST_OUTPUT;
        end else begin
          ch_cnt_d = ch_cnt_q + CH_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          tile_cnt_d = tile_cnt_q + TILE_W'(1);
          state_d    = (tile_cnt_d == num_tiles_q) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  win_acc16 u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (acc_load),
    .add_i  (acc_add),
    .m_i    ({mul_m1, mul_m2, mul_m3, mul_m4}),
    .acc_o  (acc_flat)
  );

  assign {out_m1, out_m2, out_m3, out_m4} = acc_flat;
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_win33_mul_ctrl.sv
// Scoreboard bench for win33_mul_ctrl with a small behavioural win33_mul stand-in.
module tb_win33_mul_ctrl;

  localparam int M_CONST = 0;
  localparam int M_RAMP  = 1;
  localparam int M_RAND  = 2;
  localparam int M_WRAP  = 3;
  localparam int M_FAULT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   num_ch = '0;
  logic [7:0]   num_tiles = '0;
  logic         busy, done, in_ready, mul_enable, out_valid, err, mul_end;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] mul_m1, mul_m2, mul_m3, mul_m4;
  logic [127:0] out_m1, out_m2, out_m3, out_m4;
  logic [31:0]  prod [16];

  always #5 clk = ~clk;

  win33_mul_ctrl #(.CH_W(4), .TILE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ch(num_ch), .num_tiles(num_tiles),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .mul_enable(mul_enable), .mul_end(mul_end),
    .mul_m1(mul_m1), .mul_m2(mul_m2), .mul_m3(mul_m3), .mul_m4(mul_m4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m1(out_m1), .out_m2(out_m2), .out_m3(out_m3), .out_m4(out_m4), .err(err)
  );

  // Multiplier stand-in: end_signal one cycle after enable, products held by the source
  logic run_q;
  logic stuck = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= mul_enable;
  assign mul_end = run_q & ~stuck;
  assign mul_m1 = {prod[0],  prod[1],  prod[2],  prod[3]};
  assign mul_m2 = {prod[4],  prod[5],  prod[6],  prod[7]};
  assign mul_m3 = {prod[8],  prod[9],  prod[10], prod[11]};
  assign mul_m4 = {prod[12], prod[13], prod[14], prod[15]};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0][31:0] sb_q [$];
  int cyc = 0, en_cnt = 0, en_cyc = 0, ir_cnt = 0, done_cnt = 0, done_cyc = 0;
  int ov_cyc = 0, hs_cnt = 0, hs_cyc = 0, err_cyc = 0, stall_n = 0;
  int ir_cyc_q [$];
  bit ov_prev = 0, err_prev = 0, stall_en = 0, ign_data = 0;
  logic [511:0] stall_ref;

  function automatic logic [127:0] row_of(input logic [15:0][31:0] t, input int r);
    return {t[4*r], t[4*r+1], t[4*r+2], t[4*r+3]};
  endfunction

  // Monitor: event timestamps, downstream backpressure and scoreboard compare
  always @(negedge clk) begin
    logic [15:0][31:0] exp_t;
    cyc++;
    if (mul_enable) begin en_cnt++; en_cyc = cyc; end
    if (in_ready) begin ir_cnt++; ir_cyc_q.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
    if (out_valid && !ov_prev) ov_cyc = cyc;
    ov_prev = out_valid;
    if (stall_en && hs_cnt == 1 && out_valid && stall_n < 5) begin
      if (stall_n == 0) stall_ref = {out_m1, out_m2, out_m3, out_m4};
      else begin
        check("stall_m1", out_m1, stall_ref[511:384]);
        check("stall_m4", out_m4, stall_ref[127:0]);
        check("stall_irdy", {127'd0, in_ready}, 128'd0);
      end
      stall_n++;
      out_ready = 1'b0;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      hs_cyc = cyc;
      if (sb_q.size() == 0) begin
        if (!ign_data) check("sb_empty", 128'd1, 128'd0);
      end else begin
        exp_t = sb_q.pop_front();
        check("out_m1", out_m1, row_of(exp_t, 0));
        check("out_m2", out_m2, row_of(exp_t, 1));
        check("out_m3", out_m3, row_of(exp_t, 2));
        check("out_m4", out_m4, row_of(exp_t, 3));
      end
    end
  end

  function automatic logic [31:0] gen_prod(input int mode, input int k);
    int v, u;
    case (mode)
      M_CONST: begin v = 3; u = -2; end
      M_RAMP:  begin v = k + 1; u = 2; end
      M_WRAP:  begin v = (k == 0) ? 32'h7FFFFFFF : 1; u = 1; end
      default: begin
        v = int'($urandom_range(65535)) - 32768;
        u = int'($urandom_range(65535)) - 32768;
      end
    endcase
    return 32'(v * u);
  endfunction

  task automatic start_job(input int ntiles, input int nch);
    num_tiles = 8'(ntiles);
    num_ch    = 4'(nch);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_job(input int ntiles, input int nch, input int mode);
    int eff, d0;
    bit got;
    logic [31:0] p [16][16];
    logic [15:0][31:0] exp_t;
    eff = (nch == 0) ? 1 : nch;
    d0  = done_cnt;
    start_job(ntiles, nch);
    for (int t = 0; t < ntiles; t++) begin
      for (int k = 0; k < eff; k++)
        for (int e = 0; e < 16; e++) begin
          p[k][e]  = gen_prod(mode, k);
          exp_t[e] = (k == 0) ? p[k][e] : exp_t[e] + p[k][e];
        end
      if (mode != M_FAULT) sb_q.push_back(exp_t);
      for (int k = 0; k < eff; k++) begin
        for (int e = 0; e < 16; e++) prod[e] = p[k][e];
        in_valid = 1'b1;
        got = 0;
        for (int w = 0; w < 60; w++) begin
          @(negedge clk);
          if (in_ready) begin got = 1; break; end
        end
        if (!got) begin
          check("irdy_timeout", 128'd0, 128'd1);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    for (int w = 0; w < 100; w++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    check("done_seen", {127'd0, done_cnt != d0}, 128'd1);
    @(negedge clk); @(negedge clk);
    check("done_once", 128'(done_cnt - d0), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int en0, ir0, d0;
    for (int e = 0; e < 16; e++) prod[e] = '0;
    #1;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_outs", {123'd0, done, in_ready, mul_enable, out_valid, err}, 128'd0);
    check("rst_m1", out_m1, 128'd0);
    check("rst_m4", out_m4, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single tile, single channel, 3 * -2 per lane
    run_job(1, 1, M_CONST);
    check("t1_ovld_lat", 128'(ov_cyc - en_cyc), 128'd3);
    check("t1_done_lat", 128'(done_cyc - hs_cyc), 128'd1);

    // 2: six channels, ramp products
    ir_cyc_q.delete();
    run_job(1, 6, M_RAMP);
    check("t2_irdy_cnt", 128'(ir_cyc_q.size()), 128'd6);
    for (int i = 1; i < ir_cyc_q.size(); i++)
      check("t2_irdy_gap", 128'(ir_cyc_q[i] - ir_cyc_q[i-1]), 128'd3);

    // 3: backpressure on the second tile
    hs_cnt = 0; stall_n = 0; stall_en = 1;
    run_job(3, 2, M_RAND);
    stall_en = 0;
    check("t3_handshakes", 128'(hs_cnt), 128'd3);
    check("t3_stall_len", 128'(stall_n), 128'd5);

    // 4: lane wrap 0x7FFFFFFF + 1
    run_job(1, 2, M_WRAP);

    // 5: empty job, then zero channels
    en0 = en_cnt; d0 = done_cnt;
    start_job(0, 3);
    @(negedge clk);
    check("t5_empty_done", {127'd0, done}, 128'd1);
    repeat (3) @(negedge clk);
    check("t5_empty_noen", 128'(en_cnt - en0), 128'd0);
    check("t5_empty_dcnt", 128'(done_cnt - d0), 128'd1);
    check("t5_empty_idle", {127'd0, busy}, 128'd0);
    @(posedge clk); #1;
    ir0 = ir_cnt;
    run_job(2, 0, M_RAND);
    check("t5_ch0_irdy", 128'(ir_cnt - ir0), 128'd2);

    // 6a: hung multiplier
    stuck = 1'b1; ign_data = 1;
    run_job(1, 1, M_FAULT);
    check("t6_err_lat", 128'(err_cyc - en_cyc), 128'd5);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", {127'd0, err}, 128'd1);
    stuck = 1'b0; ign_data = 0;
    @(posedge clk); #1;

    // 6b: reset in the middle of a tile, then a clean job
    start_job(2, 3);
    for (int e = 0; e < 16; e++) prod[e] = 32'h11;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {127'd0, busy}, 128'd0);
    check("t6_rst_outs", {123'd0, done, in_ready, mul_enable, out_valid, err}, 128'd0);
    check("t6_rst_m1", out_m1, 128'd0);
    check("t6_rst_m3", out_m3, 128'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(2, 2, M_RAND);
    check("t6_clean_err", {127'd0, err}, 128'd0);
    check("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
